// File: rtl/aqp_ebus_io_mailbox.sv
// Z80 I/O-port mailbox: data/status register pair at BASE_PORT/BASE_PORT+1, backed by an
// "up" FIFO (Z80 -> host) and a "down" FIFO (host -> Z80), with an IRQ on pending down-data.
module aqp_ebus_io_mailbox #(
  parameter logic [7:0] BASE_PORT  = 8'hF0,
  parameter int         DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       use_t80,
  input  logic [7:0] ebus_a,
  input  logic [7:0] ebus_d_in,
  input  logic       ebus_rd_n,
  input  logic       ebus_wr_n,
  input  logic       ebus_iorq_n,
  output logic [7:0] ebus_d_out,
  output logic       ebus_d_oe,
  output logic       irq,
  output logic [7:0] host_up_data,
  input  logic       host_up_rd,
  output logic       host_up_empty,
  input  logic [7:0] host_dn_data,
  input  logic       host_dn_wr,
  output logic       host_dn_full
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [7:0]          STAT_PORT = BASE_PORT + 8'd1;

  logic [2:0] r_q_rd;
  logic [2:0] r_q_wr;
  logic [2:0] r_vld;

  logic [7:0]          r_up_mem [0:DEPTH-1];
  logic [DEPTH_LOG2:0] r_up_wptr;
  logic [DEPTH_LOG2:0] r_up_rptr;
  logic [7:0]          r_dn_mem [0:DEPTH-1];
  logic [DEPTH_LOG2:0] r_dn_wptr;
  logic [DEPTH_LOG2:0] r_dn_rptr;

  logic       r_up_ovf;
  logic       r_dn_ovf;
  logic       r_irq_en;
  logic       r_irq;
  logic [7:0] r_rd_latch;

  logic                w_rd_edge;
  logic                w_wr_edge;
  logic                w_hit;
  logic                w_sel_data;
  logic                w_sel_stat;
  logic                w_data_rd;
  logic                w_data_wr;
  logic                w_stat_rd;
  logic                w_stat_wr;
  logic [DEPTH_LOG2:0] w_up_count;
  logic [DEPTH_LOG2:0] w_dn_count;
  logic                w_up_empty;
  logic                w_up_full;
  logic                w_dn_empty;
  logic                w_dn_full;
  logic                w_up_pop;
  logic                w_up_push;
  logic                w_up_ovf_set;
  logic                w_dn_pop;
  logic                w_dn_push;
  logic                w_dn_ovf_set;
  logic [7:0]          w_status;

  // r_vld marks which sync taps hold real post-reset samples, so a strobe already low at
  // reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q_rd <= 3'b111;
      r_q_wr <= 3'b111;
      r_vld  <= 3'b000;
    end else begin
      r_q_rd <= {r_q_rd[1:0], ebus_rd_n};
      r_q_wr <= {r_q_wr[1:0], ebus_wr_n};
      r_vld  <= {r_vld[1:0], 1'b1};
    end
  end

  assign w_rd_edge = use_t80 ? (r_vld[1] && (r_q_rd[1:0] == 2'b10))
                             : (r_vld[2] && (r_q_rd[2:1] == 2'b10));
  assign w_wr_edge = use_t80 ? (r_vld[1] && (r_q_wr[1:0] == 2'b10))
                             : (r_vld[2] && (r_q_wr[2:1] == 2'b10));

  assign w_hit      = !ebus_iorq_n && (ebus_a[7:1] == BASE_PORT[7:1]);
  assign w_sel_data = (ebus_a == BASE_PORT);
  assign w_sel_stat = (ebus_a == STAT_PORT);
  assign w_data_rd  = w_rd_edge && w_hit && w_sel_data;
  assign w_stat_rd  = w_rd_edge && w_hit && w_sel_stat;
  assign w_data_wr  = w_wr_edge && w_hit && w_sel_data;
  assign w_stat_wr  = w_wr_edge && w_hit && w_sel_stat;

  assign w_up_count = r_up_wptr - r_up_rptr;
  assign w_dn_count = r_dn_wptr - r_dn_rptr;
  assign w_up_empty = (w_up_count == '0);
  assign w_up_full  = (w_up_count == FULL_CNT);
  assign w_dn_empty = (w_dn_count == '0);
  assign w_dn_full  = (w_dn_count == FULL_CNT);

  // A Z80 push into a full up-FIFO is still accepted when the host pops in the same cycle.
  assign w_up_pop     = host_up_rd && !w_up_empty;
  assign w_up_push    = w_data_wr && (!w_up_full || w_up_pop);
  assign w_up_ovf_set = w_data_wr && w_up_full && !w_up_pop;
  assign w_dn_pop     = w_data_rd && !w_dn_empty;
  assign w_dn_push    = host_dn_wr && !w_dn_full;
  assign w_dn_ovf_set = host_dn_wr && w_dn_full;

  assign w_status = {r_irq_en, 3'b000, r_up_ovf, r_dn_ovf, w_up_full, !w_dn_empty};

  always_ff @(posedge clk) begin
    if (w_up_push) r_up_mem[r_up_wptr[DEPTH_LOG2-1:0]] <= ebus_d_in;
    if (w_dn_push) r_dn_mem[r_dn_wptr[DEPTH_LOG2-1:0]] <= host_dn_data;
  end

  // A new overflow in the same cycle as a clearing status write leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_up_wptr  <= '0;
      r_up_rptr  <= '0;
      r_dn_wptr  <= '0;
      r_dn_rptr  <= '0;
      r_up_ovf   <= 1'b0;
      r_dn_ovf   <= 1'b0;
      r_irq_en   <= 1'b0;
      r_irq      <= 1'b0;
      r_rd_latch <= 8'h00;
    end else begin
      if (w_up_push) r_up_wptr <= r_up_wptr + 1'b1;
      if (w_up_pop)  r_up_rptr <= r_up_rptr + 1'b1;
      if (w_dn_push) r_dn_wptr <= r_dn_wptr + 1'b1;
      if (w_dn_pop)  r_dn_rptr <= r_dn_rptr + 1'b1;

      if (w_data_rd) begin
        r_rd_latch <= w_dn_empty ? 8'h00 : r_dn_mem[r_dn_rptr[DEPTH_LOG2-1:0]];
      end else if (w_stat_rd) begin
        r_rd_latch <= w_status;
      end

      if (w_stat_wr) begin
        r_irq_en <= ebus_d_in[7];
        if (ebus_d_in[3]) r_up_ovf <= 1'b0;
        if (ebus_d_in[2]) r_dn_ovf <= 1'b0;
      end
      if (w_up_ovf_set) r_up_ovf <= 1'b1;
      if (w_dn_ovf_set) r_dn_ovf <= 1'b1;

      r_irq <= r_irq_en && !w_dn_empty;
    end
  end

  assign ebus_d_out    = r_rd_latch;
  assign ebus_d_oe     = !reset && !ebus_iorq_n && !ebus_rd_n && (w_sel_data || w_sel_stat);
  assign irq           = r_irq;
  assign host_up_empty = w_up_empty;
  assign host_dn_full  = w_dn_full;
  assign host_up_data  = w_up_empty ? 8'h00 : r_up_mem[r_up_rptr[DEPTH_LOG2-1:0]];

endmodule
